// File: rtl/bit_serial_mac_seq.sv
// Bit-serial MAC sequencer: streams activation bit-planes MSB first to a wordline array and accumulates signed ADC codes per column.
// Latency: result valid N+2 cycles after the input handshake (N = effective precision).
// Backpressure: single operation in flight; in_ready_o only in IDLE, result held until out_ready_i. Define BIT_SERIAL_MAC_SAT_EN to saturate results (default wraps).
module bit_serial_mac_seq #(
  parameter int IN_BITS_MAX = 8,
  parameter int IN_ELEMS    = 128,
  parameter int OUT_ELEMS   = 32,
  parameter int ADC_BITS    = 4,
  parameter int OUT_BITS    = 8,
  localparam int ACC_BITS   = ADC_BITS + IN_BITS_MAX + 1,
  localparam int BW         = $clog2(IN_BITS_MAX + 1),
  localparam int SW         = $clog2(ACC_BITS)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [IN_ELEMS*IN_BITS_MAX-1:0] in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [BW-1:0]                 cfg_bits_i,
  input  logic                          cfg_signed_i,
  input  logic [SW-1:0]                 cfg_shift_i,
  output logic [IN_ELEMS-1:0]           wl_o,
  output logic                          wl_valid_o,
  input  logic [OUT_ELEMS*ADC_BITS-1:0] adc_i,
  output logic [OUT_ELEMS*OUT_BITS-1:0] out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, OUT} state_t;

  state_t                         state_q, state_d;
  logic [BW-1:0]                  cnt_q, cnt_d;       // bit index of the plane driven this cycle
  logic                           first_q, first_d;   // next ADC sample is the MSB plane
  logic                           samp_q, samp_d;     // ADC code for last cycle's plane is present
  logic [IN_ELEMS*IN_BITS_MAX-1:0] data_q, data_d;
  logic                           signed_q, signed_d;
  logic [SW-1:0]                  shift_q, shift_d;
  logic signed [ACC_BITS-1:0]     acc_q [OUT_ELEMS];
  logic signed [ACC_BITS-1:0]     acc_d [OUT_ELEMS];
  logic [OUT_ELEMS*OUT_BITS-1:0]  out_q, out_d;

`ifdef BIT_SERIAL_MAC_SAT_EN
  localparam logic signed [ACC_BITS:0] SAT_MAX = (ACC_BITS+1)'((1 << (OUT_BITS-1)) - 1);
  localparam logic signed [ACC_BITS:0] SAT_MIN = (ACC_BITS+1)'(-(1 << (OUT_BITS-1)));
`endif

  function automatic logic signed [ACC_BITS-1:0] sext_adc(input logic [ADC_BITS-1:0] a);
    return {{(ACC_BITS-ADC_BITS){a[ADC_BITS-1]}}, a};
  endfunction

  // Round half up, arithmetic shift, then saturate or wrap. One guard bit keeps the rounding add exact.
  function automatic logic [OUT_BITS-1:0] post(input logic signed [ACC_BITS-1:0] a,
                                               input logic [SW-1:0] sh);
    logic signed [ACC_BITS:0] w;
    logic signed [ACC_BITS:0] rnd;
    logic [OUT_BITS-1:0]      res;
    w   = {a[ACC_BITS-1], a};
    rnd = '0;
    if (sh != '0) rnd = (ACC_BITS+1)'(1) << (sh - SW'(1));
    w   = (w + rnd) >>> sh;
`ifdef BIT_SERIAL_MAC_SAT_EN
    if (w > SAT_MAX)      res = SAT_MAX[OUT_BITS-1:0];
    else if (w < SAT_MIN) res = SAT_MIN[OUT_BITS-1:0];
    else                  res = w[OUT_BITS-1:0];
`else
    res = w[OUT_BITS-1:0];
`endif
    return res;
  endfunction

  // Next-state, accumulation and result formation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    samp_d   = (state_q == DRIVE);
    data_d   = data_q;
    signed_d = signed_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    out_d    = out_q;

    // ADC codes arrive one cycle behind their bit-plane.
    if (samp_q) begin
      first_d = 1'b0;
      for (int c = 0; c < OUT_ELEMS; c++) begin
        if (first_q && signed_q)
          acc_d[c] = -sext_adc(adc_i[c*ADC_BITS +: ADC_BITS]);
        else
          acc_d[c] = (acc_q[c] <<< 1) + sext_adc(adc_i[c*ADC_BITS +: ADC_BITS]);
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          data_d   = in_data_i;
          signed_d = cfg_signed_i;
          shift_d  = cfg_shift_i;
          first_d  = 1'b1;
          if (cfg_bits_i == '0 || cfg_bits_i > BW'(IN_BITS_MAX))
            cnt_d = BW'(IN_BITS_MAX - 1);
          else
            cnt_d = cfg_bits_i - BW'(1);
          for (int c = 0; c < OUT_ELEMS; c++) acc_d[c] = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - BW'(1);
      end
      DRAIN: begin
        for (int c = 0; c < OUT_ELEMS; c++)
          out_d[c*OUT_BITS +: OUT_BITS] = post(acc_d[c], shift_q);
        state_d = OUT;
      end
      OUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      samp_q   <= 1'b0;
      data_q   <= '0;
      signed_q <= 1'b0;
      shift_q  <= '0;
      out_q    <= '0;
      for (int c = 0; c < OUT_ELEMS; c++) acc_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      samp_q   <= samp_d;
      data_q   <= data_d;
      signed_q <= signed_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
      for (int c = 0; c < OUT_ELEMS; c++) acc_q[c] <= acc_d[c];
    end
  end

  // Wordline plane: bit cnt_q of every latched activation while driving.
  always_comb begin
    wl_o = '0;
    if (state_q == DRIVE)
      for (int e = 0; e < IN_ELEMS; e++)
        wl_o[e] = data_q[e*IN_BITS_MAX + int'(cnt_q)];
  end

  assign wl_valid_o  = (state_q == DRIVE);
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == OUT);
  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = out_q;

endmodule
